// File: rtl/div_unit_pkg.sv
// ============================================================================
//  Module   : div_unit_pkg
//  Purpose  : Shared definitions for the iterative restoring divider:
//             operand width, step-counter width and FSM state encodings.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

    // Number of bits needed to count 0 .. w-1 divider steps.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = cnt_width(DIV_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division step. Shifts the next
//             dividend bit into the partial remainder, trial-subtracts the
//             divisor and uses the borrow to keep or restore the remainder.
//  Ports    : rem_part  in  W  current partial remainder (always < dvs)
//             dvd_msb   in  1  dividend bit shifted in this step
//             dvs       in  W  divisor magnitude
//             rem_next  out W  partial remainder after this step
//             q_bit     out 1  quotient bit produced by this step
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
    import div_unit_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] rem_part,
    input  logic         dvd_msb,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    // The shifted remainder can reach W+1 bits (rem_part < dvs <= 2^W-1),
    // so the trial subtraction carries one extra bit to hold the borrow.
    logic [W:0]   w_shift;
    logic [W+1:0] w_trial;
    logic         w_borrow;
    logic         w_unused_hi;

    assign w_shift  = {rem_part, dvd_msb};
    assign w_trial  = {1'b0, w_shift} - {2'b00, dvs};
    assign w_borrow = w_trial[W+1];

    // Either kept value is below dvs, so the top bits are always zero.
    assign rem_next = w_borrow ? w_shift[W-1:0] : w_trial[W-1:0];
    assign q_bit    = ~w_borrow;

    assign w_unused_hi = ^{w_shift[W], w_trial[W]};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  Module   : div_unit
//  Purpose  : Iterative W-bit restoring divider for DIV/DIVU. Quotient is
//             intended for LO, remainder for HI.
//             FSM: IDLE -> PREP -> RUN (W steps) -> FIX -> DONE -> IDLE.
//             A zero divisor goes PREP -> DONE directly.
//  Config   : SIGNED_DIV_EN - when defined, is_signed selects two's
//             complement division (magnitudes in PREP, sign fix in FIX).
//             When undefined every operation is unsigned; PREP and FIX
//             remain as pass-through cycles so latency is unchanged.
//  Ports    : clk        in   1  rising-edge clock
//             rst        in   1  synchronous active-high reset
//             start      in   1  division request, sampled only in IDLE
//             is_signed  in   1  1 = DIV, 0 = DIVU
//             dividend   in   W  numerator, captured on accepted start
//             divisor    in   W  denominator, captured on accepted start
//             busy       out  1  high in PREP, RUN and FIX
//             done       out  1  one-cycle result-valid pulse
//             quot       out  W  quotient, held until next result
//             rem        out  W  remainder, held until next result
//             div0       out  1  divisor was zero, valid with done
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         div0
);

    // The default width reuses the shared constant.
    localparam int CNT_W = (W == DIV_W) ? DIV_CNT_W : cnt_width(W);
    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(W - 1);

    div_state_e r_state;
    div_state_e w_state_next;

    // r_dvd holds the dividend, then its magnitude, and during RUN it shifts
    // out dividend bits at the top while quotient bits enter at the bottom.
    logic [W-1:0]     r_dvd;
    logic [W-1:0]     r_dvs;
    logic [W-1:0]     r_rem_part;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [W-1:0]     r_quot;
    logic [W-1:0]     r_rem;
    logic             r_div0;

    logic             w_signed;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [W-1:0]     w_dvd_mag;
    logic [W-1:0]     w_dvs_mag;
    logic             w_dvs_zero;
    logic [W-1:0]     w_rem_next;
    logic             w_q_bit;
    logic [W-1:0]     w_quot_fix;
    logic [W-1:0]     w_rem_fix;

`ifdef SIGNED_DIV_EN
    logic r_is_signed;
    assign w_signed = r_is_signed;
`else
    logic w_unused_is_signed;
    assign w_signed           = 1'b0;
    assign w_unused_is_signed = is_signed;
`endif

    // ------------------------------------------------------------------
    // Operand conditioning and result sign correction.
    // The magnitude of the most negative value wraps to itself, which is
    // the correct magnitude when read as unsigned.
    // ------------------------------------------------------------------
    always_comb begin
        w_dvd_neg  = w_signed & r_dvd[W-1];
        w_dvs_neg  = w_signed & r_dvs[W-1];
        w_dvd_mag  = w_dvd_neg ? -r_dvd : r_dvd;
        w_dvs_mag  = w_dvs_neg ? -r_dvs : r_dvs;
        w_dvs_zero = (r_dvs == '0);
        w_quot_fix = r_q_neg ? -r_dvd : r_dvd;
        w_rem_fix  = r_r_neg ? -r_rem_part : r_rem_part;
    end

    div_step #(
        .W (W)
    ) u_step (
        .rem_part (r_rem_part),
        .dvd_msb  (r_dvd[W-1]),
        .dvs      (r_dvs),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_PREP;
                end
            end
            S_PREP: begin
                busy         = 1'b1;
                w_state_next = w_dvs_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_LAST_STEP) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                busy         = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem_part <= '0;
            r_cnt      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_div0     <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_is_signed <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd <= dividend;
                        r_dvs <= divisor;
`ifdef SIGNED_DIV_EN
                        r_is_signed <= is_signed;
`endif
                    end
                end
                S_PREP: begin
                    r_dvd      <= w_dvd_mag;
                    r_dvs      <= w_dvs_mag;
                    r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
                    // Truncating division: remainder follows the dividend.
                    r_r_neg    <= w_dvd_neg;
                    r_rem_part <= '0;
                    r_cnt      <= '0;
                    if (w_dvs_zero) begin
                        // r_dvd still holds the raw captured dividend here.
                        r_quot <= '1;
                        r_rem  <= r_dvd;
                        r_div0 <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_rem_part <= w_rem_next;
                    r_dvd      <= {r_dvd[W-2:0], w_q_bit};
                    r_cnt      <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_quot <= w_quot_fix;
                    r_rem  <= w_rem_fix;
                    r_div0 <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign quot = r_quot;
    assign rem  = r_rem;
    assign div0 = r_div0;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Self-checking bench for div_unit. A behavioural model of the
//             divider predicts busy/done timing and results every cycle;
//             directed operations also check hand-computed literal values.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

`ifdef SIGNED_DIV_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div0;

    int checks   = 0;
    int failures = 0;

    div_unit #(
        .W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quot      (quot),
        .rem       (rem),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: results from plain arithmetic
    // ------------------------------------------------------------------
    function automatic res_t model_fn(input logic [31:0] a, input logic [31:0] b,
                                      input logic s);
        res_t x;
        x.z = 1'b0;
        if (b == 32'd0) begin
            x.q = 32'hFFFF_FFFF;
            x.r = a;
            x.z = 1'b1;
        end else if (SGN && s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                x.q = 32'h8000_0000;
                x.r = 32'd0;
            end else begin
                x.q = $signed(a) / $signed(b);
                x.r = $signed(a) % $signed(b);
            end
        end else begin
            x.q = a / b;
            x.r = a % b;
        end
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model timing state: accepted start at cycle m_t0; done expected at
    // m_t0 + latency (1 for zero divisor, 34 otherwise).
    int   cyc = 0;
    int   m_t0 = 0;
    bit   m_active = 1'b0;
    res_t m_res = '0;
    logic [31:0] hold_q = 32'd0;
    logic [31:0] hold_r = 32'd0;
    bit   chk_en = 1'b0;

    function automatic int lat_of(input res_t x);
        return x.z ? 1 : 34;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_active <= 1'b0;
            hold_q   <= 32'd0;
            hold_r   <= 32'd0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_t0     <= cyc + 1;
                m_res    <= model_fn(dividend, divisor, is_signed);
            end
        end else if ((cyc + 1 - m_t0) > lat_of(m_res)) begin
            m_active <= 1'b0;
            hold_q   <= m_res.q;
            hold_r   <= m_res.r;
        end
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            int  age;
            bit  e_busy;
            bit  e_done;
            age    = cyc - m_t0;
            e_busy = m_active && (age < lat_of(m_res));
            e_done = m_active && (age == lat_of(m_res));
            chk("model busy", {31'd0, busy}, {31'd0, e_busy});
            chk("model done", {31'd0, done}, {31'd0, e_done});
            if (e_done) begin
                chk("model quot", quot, m_res.q);
                chk("model rem",  rem,  m_res.r);
                chk("model div0", {31'd0, div0}, {31'd0, m_res.z});
            end else if (!m_active) begin
                chk("model hold quot", quot, hold_q);
                chk("model hold rem",  rem,  hold_r);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed operation with literal expectations. poke_at >= 0 pulses a
    // stray start (with different operands) that many cycles in.
    // ------------------------------------------------------------------
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez, input int elat, input int poke_at);
        int ts;
        bit seen;
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(negedge clk);
        start = 1'b0;
        ts    = cyc;
        seen  = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (i == poke_at) begin
                start    = 1'b1;
                dividend = 32'h1234_5678;
                divisor  = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({nm, " done seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({nm, " quot"},    quot, eq);
            chk({nm, " rem"},     rem,  er);
            chk({nm, " div0"},    {31'd0, div0}, {31'd0, ez});
            chk({nm, " latency"}, cyc - ts, elat);
        end
        @(negedge clk);
    endtask

    initial begin
        bit saw_done;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quot", quot, 32'd0);
        chk("reset rem",  rem,  32'd0);
        chk("reset div0", {31'd0, div0}, 32'd0);
        @(negedge clk);

        run_op("divu 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, -1);
        run_op("divu max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, -1);
`ifdef SIGNED_DIV_EN
        run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, -1);
        run_op("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, -1);
        run_op("div -100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, -1);
        run_op("div 100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 34, -1);
`else
        run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, -1);
        run_op("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 34, -1);
        run_op("div -100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'h2492_4916, 32'd2, 1'b0, 34, -1);
        run_op("div 100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'd0, 32'd100, 1'b0, 34, -1);
`endif
        run_op("div0 5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, -1);
        run_op("divu busy start", 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, 1'b0, 34, 11);

        // Reset in the middle of an operation.
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort no done", {31'd0, saw_done}, 32'd0);
        run_op("divu 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, -1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
